hazard_stall_unit: RTL

Stall/flush controller for the 5-stage pipeline; the counterpart to the forwarding logic. Hazards that bypassing cannot resolve are handled here by holding PC and IF/ID and injecting a bubble into ID/EX:
- load-use
- branch operands resolved in ID
- HI/LO access while the multi-cycle mult/div is busy

It also tracks the destinations of in-flight EX and MEM instructions internally and flushes IF/ID on a taken branch.

---
 rtl/hazard_stall_unit_pkg.sv | 46 ++++
 rtl/hazard_stall_unit_muldiv_busy_counter.sv | 38 +++
 rtl/hazard_stall_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg
// Shared pipeline definitions for the hazard/stall controller:
//   - stall cause encodings reported on stall_cause
//   - the in-flight instruction tracker record {valid, wr, load, dest}
//   - a helper that tests an ID instruction's sources against a tracker
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    STALL_NONE    = 2'b00,
    STALL_LOADUSE = 2'b01,
    STALL_BRANCH  = 2'b10,
    STALL_MULDIV  = 2'b11
  } stall_cause_e;

  // Tracker destinations are stored at a fixed width so the record type can
  // live in the package; the top zero-extends its ADDR_W-wide addresses.
  // ADDR_W must not exceed this width.
  localparam int TRACK_ADDR_W = 8;

  // Mult/div occupancy counter width (MULDIV_LAT range 1..15).
  localparam int MULDIV_CNT_W = 4;

  typedef struct packed {
    logic                    valid;
    logic                    wr;
    logic                    load;
    logic [TRACK_ADDR_W-1:0] dest;
  } tracker_t;

  localparam tracker_t TRACKER_IDLE = '{valid: 1'b0, wr: 1'b0, load: 1'b0, dest: '0};

  // True when the tracked instruction writes a non-zero GPR that the ID
  // instruction actually reads on either source port.
  function automatic logic tracker_match(
    input tracker_t                trk,
    input logic                    uses_rs,
    input logic [TRACK_ADDR_W-1:0] rs,
    input logic                    uses_rt,
    input logic [TRACK_ADDR_W-1:0] rt
  );
    logic src_hit;
    src_hit = (uses_rs && (rs == trk.dest)) || (uses_rt && (rt == trk.dest));
    return trk.valid && trk.wr && (trk.dest != '0) && src_hit;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_muldiv_busy_counter.sv
// muldiv_busy_counter
// Tracks how many more cycles the multi-cycle mult/div unit owns HI/LO.
// Loaded with LAT when a mult/div leaves ID, then counts down to zero and
// holds there. busy is high while the count is non-zero.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous, active-high reset (count -> 0)
//   load  in   a mult/div is issuing this cycle
//   busy  out  count is non-zero
module muldiv_busy_counter
  import hazard_stall_unit_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  localparam logic [MULDIV_CNT_W-1:0] LAT_CNT = MULDIV_CNT_W'(LAT);

  logic [MULDIV_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LAT_CNT;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Stall/flush controller for the 5-stage pipeline. Resolves the hazards the
// forwarding network cannot: load-use, branch operands needed in ID, and
// HI/LO access while mult/div is still running. A stall holds PC and IF/ID
// and injects a bubble into ID/EX; a taken branch that is not stalled
// flushes IF/ID.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs, id_rt             source register addresses
//   id_uses_rs, id_uses_rt   source is actually read
//   id_is_branch             branch / jump-register resolved in ID
//   id_reg_write             ID instruction writes a GPR
//   id_mem_read              ID instruction is a load
//   id_dest                  final destination register
//   id_is_muldiv             ID instruction starts mult/div
//   id_reads_hilo            ID instruction is mfhi/mflo
//   branch_taken             branch outcome computed in ID
//   pc_write, ifid_write     PC / IF/ID update enables
//   ifid_flush               zero IF/ID on next edge
//   idex_bubble              load NOP into ID/EX on next edge
//   stall_cause              00 none, 01 load-use, 10 branch, 11 muldiv
//   muldiv_busy              mult/div still owns HI/LO
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int MULDIV_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_is_muldiv,
  input  logic              id_reads_hilo,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        stall_cause,
  output logic              muldiv_busy
);

  tracker_t ex_q;
  tracker_t mem_q;

  logic [TRACK_ADDR_W-1:0] rs_ext;
  logic [TRACK_ADDR_W-1:0] rt_ext;
  logic [TRACK_ADDR_W-1:0] dest_ext;

  logic match_ex;
  logic match_mem;
  logic load_use;
  logic br_haz;
  logic md_haz;
  logic stall;
  logic issue;

  stall_cause_e cause;

  assign rs_ext   = TRACK_ADDR_W'(id_rs);
  assign rt_ext   = TRACK_ADDR_W'(id_rt);
  assign dest_ext = TRACK_ADDR_W'(id_dest);

  assign match_ex  = tracker_match(ex_q,  id_uses_rs, rs_ext, id_uses_rt, rt_ext);
  assign match_mem = tracker_match(mem_q, id_uses_rs, rs_ext, id_uses_rt, rt_ext);

  // A load in EX cannot forward to anyone in time. A branch compares in ID,
  // so it also waits for an ALU result in EX, and for a load until it has
  // left MEM.
  assign load_use = id_valid && ex_q.load && match_ex;
  assign br_haz   = id_valid && id_is_branch && (match_ex || (mem_q.load && match_mem));
  assign md_haz   = id_valid && muldiv_busy && (id_reads_hilo || id_is_muldiv);

  assign stall = load_use || br_haz || md_haz;
  assign issue = id_valid && !stall;

  always_comb begin
    cause = STALL_NONE;
    if (load_use) begin
      cause = STALL_LOADUSE;
    end else if (br_haz) begin
      cause = STALL_BRANCH;
    end else if (md_haz) begin
      cause = STALL_MULDIV;
    end
  end

  assign pc_write    = !stall;
  assign ifid_write  = !stall;
  assign idex_bubble = stall;
  assign stall_cause = cause;
  // A stalled branch is re-evaluated when released, so no flush while held.
  assign ifid_flush  = id_valid && id_is_branch && branch_taken && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= TRACKER_IDLE;
      mem_q <= TRACKER_IDLE;
    end else begin
      mem_q <= ex_q;
      if (issue) begin
        ex_q <= '{valid: 1'b1, wr: id_reg_write, load: id_mem_read, dest: dest_ext};
      end else begin
        ex_q <= TRACKER_IDLE;
      end
    end
  end

  muldiv_busy_counter #(
    .LAT (MULDIV_LAT)
  ) u_muldiv_busy_counter (
    .clk  (clk),
    .rst  (rst),
    .load (issue && id_is_muldiv),
    .busy (muldiv_busy)
  );

endmodule
